// File: rtl/stack_tos.sv
// Forth data/return stack with a register-held top-of-stack, depth count,
// PICK read port and sticky over/underflow flags.
module stack_tos #(
   parameter int DEPTH = 64,
   parameter int DSZ   = 32,
   parameter int SSZ   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [2:0]     op,
   input  logic [DSZ-1:0] vi,
   input  logic [SSZ-1:0] pidx,
   output logic [DSZ-1:0] tos,
   output logic [DSZ-1:0] pick_vo,
   output logic           pick_vld,
   output logic [SSZ:0]   depth,
   output logic           empty,
   output logic           full,
   output logic           ovf,
   output logic           udf
);

   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_REPL = 3'd3;
   localparam logic [2:0] OP_SWAP = 3'd4;
   localparam logic [2:0] OP_PICK = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;

   localparam logic [SSZ:0] ONE  = (SSZ+1)'(1);
   localparam logic [SSZ:0] TWO  = (SSZ+1)'(2);
   localparam logic [SSZ:0] DMAX = (SSZ+1)'(DEPTH);

   logic [DSZ-1:0] ss [DEPTH-2:0];

   logic [SSZ:0]   nm1, nm2, pk;
   logic [SSZ:0]   pidx_x;
   logic [DSZ-1:0] nos, pkv;

   // Slot indices relative to the current depth; reads are only used when guarded.
   assign pidx_x = {1'b0, pidx};
   assign nm1    = depth - ONE;
   assign nm2    = depth - TWO;
   assign pk     = nm1 - pidx_x;
   assign nos    = ss[nm2[SSZ-1:0]];
   assign pkv    = ss[pk[SSZ-1:0]];

   assign empty  = (depth == '0);
   assign full   = (depth == DMAX);

   always_ff @(posedge clk) begin
      if (!rst) begin
         tos      <= '0;
         pick_vo  <= '0;
         pick_vld <= 1'b0;
         depth    <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else begin
         pick_vld <= 1'b0;
         if (en) begin
            case (op)
               OP_PUSH: begin
                  if (full) ovf <= 1'b1;
                  else begin
                     if (!empty) ss[nm1[SSZ-1:0]] <= tos;
                     tos   <= vi;
                     depth <= depth + ONE;
                  end
               end
               OP_POP: begin
                  if (empty) udf <= 1'b1;
                  else begin
                     tos   <= (depth >= TWO) ? nos : '0;
                     depth <= nm1;
                  end
               end
               OP_REPL: begin
                  if (empty) udf <= 1'b1;
                  else       tos <= vi;
               end
               OP_SWAP: begin
                  if (depth < TWO) udf <= 1'b1;
                  else begin
                     tos              <= nos;
                     ss[nm2[SSZ-1:0]] <= tos;
                  end
               end
               OP_PICK: begin
                  pick_vld <= 1'b1;
                  if (pidx == '0)          pick_vo <= tos;
                  else if (pidx_x < depth) pick_vo <= pkv;
                  else begin
                     pick_vo <= '0;
                     udf     <= 1'b1;
                  end
               end
               OP_CLR: begin
                  depth <= '0;
                  tos   <= '0;
                  ovf   <= 1'b0;
                  udf   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
